// File: rtl/score_digit_driver_if.sv
// Score-display bundle: binary load handshake plus per-pixel digit lookup.
// The master drives value/load and pixel coordinates; the slave returns status and glyph addressing.
interface score_digit_driver_if;
  logic [13:0] value_i;
  logic        load_i;
  logic        busy_o;
  logic        done_o;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [3:0]  digit_o;
  logic [3:0]  glyph_x_o;
  logic [3:0]  glyph_y_o;
  logic        digit_en_o;

  modport master (
    output value_i, load_i, pix_x, pix_y,
    input  busy_o, done_o, digit_o, glyph_x_o, glyph_y_o, digit_en_o
  );

  modport slave (
    input  value_i, load_i, pix_x, pix_y,
    output busy_o, done_o, digit_o, glyph_x_o, glyph_y_o, digit_en_o
  );
endinterface

// File: rtl/score_digit_driver.sv
// Four-digit score overlay: double-dabble conversion in 14 cycles (load ignored while busy),
// pixel-to-glyph lookup registered with 1 cycle latency against the current display register.
module score_digit_driver #(
  parameter logic [9:0] ORIGIN_X = 10'd16,
  parameter logic [9:0] ORIGIN_Y = 10'd16,
  parameter int         SCALE_SH = 0
) (
  input  logic                 vga_clk,
  input  logic                 sys_rst_n,
  score_digit_driver_if.slave  bus
);

  typedef enum logic {IDLE, CONVERT} state_t;

  localparam logic [10:0] OX    = {1'b0, ORIGIN_X};
  localparam logic [10:0] OY    = {1'b0, ORIGIN_Y};
  localparam logic [10:0] REG_W = 11'd32 << SCALE_SH;
  localparam logic [10:0] REG_H = 11'd8 << SCALE_SH;

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d;
  logic        done_q, done_d;

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Only the low 3 bits of the thousands nibble survive the shift; the top bit is always 0 for <=9999.
  logic [14:0] bcd_adj;
  logic [15:0] bcd_step;

  always_comb begin
    bcd_adj  = {3'(dd_adj(bcd_q[15:12])), dd_adj(bcd_q[11:8]),
                dd_adj(bcd_q[7:4]), dd_adj(bcd_q[3:0])};
    bcd_step = {bcd_adj, bin_q[13]};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_i) begin
          bin_d   = (bus.value_i > 14'd9999) ? 14'd9999 : bus.value_i;
          bcd_d   = 16'd0;
          cnt_d   = 4'd0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bin_d = {bin_q[12:0], 1'b0};
        bcd_d = bcd_step;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          disp_d  = bcd_step;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      bin_q   <= 14'd0;
      bcd_q   <= 16'd0;
      cnt_q   <= 4'd0;
      disp_q  <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy_o = (state_q == CONVERT);
  assign bus.done_o = done_q;

  // 11-bit arithmetic keeps coordinates left of / above the origin from wrapping into the region.
  logic [10:0] dx, dy;
  logic        in_reg;
  logic [1:0]  idx;
  logic [3:0]  lead;
  logic [3:0]  sel_dig;

  always_comb begin
    dx     = {1'b0, bus.pix_x} - OX;
    dy     = {1'b0, bus.pix_y} - OY;
    in_reg = ({1'b0, bus.pix_x} >= OX) && (dx < REG_W) &&
             ({1'b0, bus.pix_y} >= OY) && (dy < REG_H);
    idx    = 2'(dx >> (3 + SCALE_SH));
    lead[0] = (disp_q[15:12] == 4'd0);
    lead[1] = lead[0] && (disp_q[11:8] == 4'd0);
    lead[2] = lead[1] && (disp_q[7:4] == 4'd0);
    lead[3] = 1'b0;
    case (idx)
      2'd0:    sel_dig = disp_q[15:12];
      2'd1:    sel_dig = disp_q[11:8];
      2'd2:    sel_dig = disp_q[7:4];
      default: sel_dig = disp_q[3:0];
    endcase
  end

  logic [3:0] digit_q, digit_d, gx_q, gx_d, gy_q, gy_d;
  logic       en_q, en_d;

  always_comb begin
    digit_d = 4'd0;
    gx_d    = 4'd0;
    gy_d    = 4'd0;
    en_d    = 1'b0;
    if (in_reg && !lead[idx]) begin
      en_d    = 1'b1;
      digit_d = sel_dig;
      gx_d    = {1'b0, 3'(dx >> SCALE_SH)};
      gy_d    = {1'b0, 3'(dy >> SCALE_SH)};
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      digit_q <= 4'd0;
      gx_q    <= 4'd0;
      gy_q    <= 4'd0;
      en_q    <= 1'b0;
    end else begin
      digit_q <= digit_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      en_q    <= en_d;
    end
  end

  assign bus.digit_o    = digit_q;
  assign bus.glyph_x_o  = gx_q;
  assign bus.glyph_y_o  = gy_q;
  assign bus.digit_en_o = en_q;

endmodule

// File: tb/tb_score_digit_driver.sv
// Bench for score_digit_driver: two instances (scale 0 and 1) sharing the load stream,
// checked against an arithmetic decimal/pixel model.
module tb_score_digit_driver;
  localparam int OX = 16;
  localparam int OY = 16;

  logic vga_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  score_digit_driver_if if0();
  score_digit_driver_if if1();

  score_digit_driver #(.ORIGIN_X(10'd16), .ORIGIN_Y(10'd16), .SCALE_SH(0)) dut0 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .bus(if0));
  score_digit_driver #(.ORIGIN_X(10'd16), .ORIGIN_Y(10'd16), .SCALE_SH(1)) dut1 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .bus(if1));

  assign if1.value_i = if0.value_i;
  assign if1.load_i  = if0.load_i;

  always #5 vga_clk = ~vga_clk;

  int vectors     = 0;
  int miscompares = 0;
  int shown       = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  // Expected {en, digit, gx, gy} from the decimal value and pixel geometry.
  function automatic logic [12:0] model(input int sc, input int px, input int py, input int v);
    int dx, dy, idx, ndig;
    logic [3:0] dig;
    dx = px - OX;
    dy = py - OY;
    if (dx < 0 || dy < 0 || dx >= (32 << sc) || dy >= (8 << sc)) return 13'd0;
    idx  = dx >> (3 + sc);
    ndig = (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
    if (idx < 4 - ndig) return 13'd0;
    case (idx)
      0:       dig = 4'(v / 1000);
      1:       dig = 4'((v / 100) % 10);
      2:       dig = 4'((v / 10) % 10);
      default: dig = 4'(v % 10);
    endcase
    return {1'b1, dig, 4'((dx >> sc) % 8), 4'((dy >> sc) % 8)};
  endfunction

  function automatic logic [12:0] obs(input int which);
    if (which == 0) return {if0.digit_en_o, if0.digit_o, if0.glyph_x_o, if0.glyph_y_o};
    return {if1.digit_en_o, if1.digit_o, if1.glyph_x_o, if1.glyph_y_o};
  endfunction

  task automatic pix(input int x0, input int y0, input int x1, input int y1, input string tag);
    if0.pix_x = 10'(x0);
    if0.pix_y = 10'(y0);
    if1.pix_x = 10'(x1);
    if1.pix_y = 10'(y1);
    tick;
    chk({tag, "_s0"}, 32'(obs(0)), 32'(model(0, x0, y0, shown)));
    chk({tag, "_s1"}, 32'(obs(1)), 32'(model(1, x1, y1, shown)));
  endtask

  task automatic convert(input int val, input int inj_cycle, input int inj_val);
    int nbusy, ndone, done_at, target;
    nbusy   = 0;
    ndone   = 0;
    done_at = -1;
    target  = (val > 9999) ? 9999 : val;
    if0.pix_x = 10'(OX + 27);
    if0.pix_y = 10'(OY + 5);
    if0.value_i = 14'(val);
    if0.load_i  = 1'b1;
    tick;
    for (int i = 0; i < 20; i++) begin
      if (i == inj_cycle) begin
        if0.value_i = 14'(inj_val);
        if0.load_i  = 1'b1;
      end else begin
        if0.load_i  = 1'b0;
      end
      nbusy += int'(if0.busy_o);
      chk("conv_units_pixel", 32'(obs(0)), 32'(model(0, OX + 27, OY + 5, shown)));
      if (if0.done_o === 1'b1) begin
        ndone++;
        done_at = i;
        chk("busy_at_done", 32'(if0.busy_o), 32'd0);
        shown = target;
      end
      tick;
    end
    if0.load_i = 1'b0;
    chk("busy_cycles", 32'(nbusy), 32'd14);
    chk("done_pulses", 32'(ndone), 32'd1);
    chk("done_cycle", 32'(done_at), 32'd14);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nb, nd, v;
    if0.value_i = 14'd0;
    if0.load_i  = 1'b0;
    if0.pix_x   = 10'(OX + 24);
    if0.pix_y   = 10'(OY);
    if1.pix_x   = 10'(OX + 48);
    if1.pix_y   = 10'(OY);
    tick;
    tick;
    chk("rst_busy", 32'(if0.busy_o), 32'd0);
    chk("rst_done", 32'(if0.done_o), 32'd0);
    chk("rst_pix0", 32'(obs(0)), 32'd0);
    chk("rst_pix1", 32'(obs(1)), 32'd0);
    sys_rst_n = 1'b1;
    pix(OX + 24, OY, OX + 48, OY, "post_rst_units");

    convert(1234, -1, 0);
    pix(OX + 8, OY + 3, OX + 17, OY + 3, "r032");
    chk("r032_digit", 32'(if0.digit_o), 32'd2);
    chk("r032_gx", 32'(if0.glyph_x_o), 32'd0);
    chk("r032_gy", 32'(if0.glyph_y_o), 32'd3);
    chk("r032_en", 32'(if0.digit_en_o), 32'd1);
    chk("s1_idx1_gx", 32'(if1.glyph_x_o), 32'd0);
    chk("s1_idx1_digit", 32'(if1.digit_o), 32'd2);

    convert(9999, -1, 0);
    for (int c = 0; c < 4; c++) begin
      pix(OX + c * 8 + 1, OY + 1, OX + c * 16, OY, "r033a");
      chk("r033a_digit", 32'(if0.digit_o), 32'd9);
    end
    convert(12000, -1, 0);
    for (int c = 0; c < 4; c++) begin
      pix(OX + c * 8 + 2, OY + 6, OX + c * 16 + 3, OY + 9, "r033b");
      chk("r033b_digit", 32'(if0.digit_o), 32'd9);
    end

    convert(7, -1, 0);
    for (int c = 0; c < 4; c++) begin
      pix(OX + c * 8 + 4, OY + 2, OX + c * 16 + 5, OY + 2, "r034_7");
      chk("r034_7_en", 32'(if0.digit_en_o), (c == 3) ? 32'd1 : 32'd0);
    end
    chk("r034_7_digit", 32'(if0.digit_o), 32'd7);
    convert(0, -1, 0);
    for (int c = 0; c < 4; c++) begin
      pix(OX + c * 8, OY, OX + c * 16, OY, "r034_0");
      chk("r034_0_en", 32'(if0.digit_en_o), (c == 3) ? 32'd1 : 32'd0);
    end

    pix(OX - 1, OY + 3, OX - 1, OY + 3, "bnd_left");
    chk("bnd_left_en", 32'(if0.digit_en_o), 32'd0);
    pix(OX + 32, OY + 3, OX + 64, OY + 3, "bnd_right");
    chk("bnd_right_en", 32'(if0.digit_en_o), 32'd0);
    pix(OX + 31, OY + 7, OX + 63, OY + 15, "bnd_corner");
    chk("bnd_corner_gx", 32'(if0.glyph_x_o), 32'd7);
    chk("bnd_corner_gy", 32'(if0.glyph_y_o), 32'd7);
    pix(OX + 5, OY - 1, OX + 5, OY + 16, "bnd_vert");
    pix(0, 0, 1023, 1023, "bnd_extreme");

    convert(7, -1, 0);
    convert(1234, 5, 5678);
    pix(OX + 27, OY + 5, OX + 55, OY + 5, "r035_after");
    chk("r035_digit", 32'(if0.digit_o), 32'd4);

    if0.pix_x   = 10'(OX + 26);
    if0.pix_y   = 10'(OY + 1);
    if0.value_i = 14'd4321;
    if0.load_i  = 1'b1;
    tick;
    if0.load_i = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    sys_rst_n = 1'b0;
    #1;
    chk("r036_busy", 32'(if0.busy_o), 32'd0);
    chk("r036_done", 32'(if0.done_o), 32'd0);
    chk("r036_en", 32'(if0.digit_en_o), 32'd0);
    shown = 0;
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      nb += int'(if0.busy_o);
      nd += int'(if0.done_o);
    end
    chk("r036_no_done", 32'(nd), 32'd0);
    chk("r036_no_busy", 32'(nb), 32'd0);
    for (int c = 0; c < 4; c++) pix(OX + c * 8 + 3, OY + 4, OX + c * 16 + 9, OY + 11, "r036_cells");

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 120));
      else v = int'($urandom_range(0, 16383));
      convert(v, (n % 3 == 0) ? int'($urandom_range(1, 12)) : -1, int'($urandom_range(0, 16383)));
      for (int k = 0; k < 12; k++) begin
        pix(int'($urandom_range(OX - 4, OX + 36)), int'($urandom_range(OY - 3, OY + 10)),
            int'($urandom_range(OX - 4, OX + 68)), int'($urandom_range(OY - 3, OY + 18)), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
